// File: rtl/axi_mem_arbiter_if.sv
// Single-beat AXI bundle shared by the IFU, LSU and memory sides of
// axi_mem_arbiter. Only the signals a single-beat, no-ID transaction
// needs are carried; burst length is implicitly zero.
// Modports:
//   master - the side that issues requests (IFU/LSU, or the arbiter downstream)
//   slave  - the side that answers them (the arbiter upstream, or memory)
interface axi_mem_arbiter_if #(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64
);

   logic [ADDR_W-1:0]   aw_addr;
   logic                aw_valid;
   logic                aw_ready;

   logic [DATA_W-1:0]   w_data;
   logic [DATA_W/8-1:0] w_strb;
   logic                w_valid;
   logic                w_ready;

   logic                b_valid;
   logic                b_ready;

   logic [ADDR_W-1:0]   ar_addr;
   logic                ar_valid;
   logic                ar_ready;

   logic [DATA_W-1:0]   r_data;
   logic                r_valid;
   logic                r_ready;

   modport master (
      output aw_addr, aw_valid,
      input  aw_ready,
      output w_data, w_strb, w_valid,
      input  w_ready,
      input  b_valid,
      output b_ready,
      output ar_addr, ar_valid,
      input  ar_ready,
      input  r_data, r_valid,
      output r_ready
   );

   modport slave (
      input  aw_addr, aw_valid,
      output aw_ready,
      input  w_data, w_strb, w_valid,
      output w_ready,
      output b_valid,
      input  b_ready,
      input  ar_addr, ar_valid,
      output ar_ready,
      output r_data, r_valid,
      input  r_ready
   );

endinterface

// File: rtl/axi_mem_arbiter.sv
// axi_mem_arbiter
// Shares the single 64-bit AXI memory port between the IFU (s0, read-only)
// and the LSU (s1, read/write). One single-beat transaction is in flight at
// a time and the grant is held until its response handshake completes.
//
// Arbitration happens only in IDLE: LSU write > LSU read > IFU read.
// Optional build macro ARB_ROUND_ROBIN_EN: when both reads are pending, the
// read that was not served last wins (the LSU write still has absolute
// priority). The last_rd register exists only in that build.
//
// s0's write channels are never used; the arbiter holds their ready/valid
// outputs at 0.
module axi_mem_arbiter #(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64
) (
   input  logic                 clk,
   input  logic                 rst_n,
   axi_mem_arbiter_if.slave     s0,
   axi_mem_arbiter_if.slave     s1,
   axi_mem_arbiter_if.master    m,
   output logic [1:0]           grant
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD0  = 2'd1,
      RD1  = 2'd2,
      WR1  = 2'd3
   } state_t;

   localparam logic [1:0] GRANT_NONE = 2'b00;
   localparam logic [1:0] GRANT_RD0  = 2'b01;
   localparam logic [1:0] GRANT_RD1  = 2'b10;
   localparam logic [1:0] GRANT_WR1  = 2'b11;

   state_t     state;
   state_t     state_next;
   logic [1:0] grant_next;

   logic ar_done;
   logic aw_done;
   logic w_done;

   logic ar_hs;
   logic r_hs;
   logic aw_hs;
   logic w_hs;
   logic b_hs;

   logic wr_req;
   logic both_rd;

`ifdef ARB_ROUND_ROBIN_EN
   logic last_rd;
`endif

   // Address and data pass straight through; only valid/ready are gated by
   // the grant, so these buses need no steering except the shared AR address.
   assign m.aw_addr = s1.aw_addr;
   assign m.w_data  = s1.w_data;
   assign m.w_strb  = s1.w_strb;
   assign m.ar_addr = (state == RD1) ? s1.ar_addr : s0.ar_addr;
   assign s0.r_data = m.r_data;
   assign s1.r_data = m.r_data;

   // Handshakes are observed on the downstream side, which already carries
   // the grant gating and the done-flag masking.
   assign ar_hs = m.ar_valid & m.ar_ready;
   assign r_hs  = m.r_valid  & m.r_ready;
   assign aw_hs = m.aw_valid & m.aw_ready;
   assign w_hs  = m.w_valid  & m.w_ready;
   assign b_hs  = m.b_valid  & m.b_ready;

   // A write request is either half of the write address/data pair.
   assign wr_req  = s1.aw_valid | s1.w_valid;
   assign both_rd = s0.ar_valid & s1.ar_valid;

   // Route valid/ready between the granted master and the memory port;
   // everything not routed stays 0 so a waiting master sees no activity.
   always_comb begin
      m.aw_valid  = 1'b0;
      m.w_valid   = 1'b0;
      m.b_ready   = 1'b0;
      m.ar_valid  = 1'b0;
      m.r_ready   = 1'b0;

      s0.aw_ready = 1'b0;
      s0.w_ready  = 1'b0;
      s0.b_valid  = 1'b0;
      s0.ar_ready = 1'b0;
      s0.r_valid  = 1'b0;

      s1.aw_ready = 1'b0;
      s1.w_ready  = 1'b0;
      s1.b_valid  = 1'b0;
      s1.ar_ready = 1'b0;
      s1.r_valid  = 1'b0;

      case (state)
         RD0: begin
            // Once the AR beat is taken, both valid and ready are masked so a
            // follow-on IFU request cannot slip through and stays pending.
            m.ar_valid  = s0.ar_valid & ~ar_done;
            s0.ar_ready = m.ar_ready & ~ar_done;
            s0.r_valid  = m.r_valid;
            m.r_ready   = s0.r_ready;
         end
         RD1: begin
            m.ar_valid  = s1.ar_valid & ~ar_done;
            s1.ar_ready = m.ar_ready & ~ar_done;
            s1.r_valid  = m.r_valid;
            m.r_ready   = s1.r_ready;
         end
         WR1: begin
            // AW and W travel independently; each beat is forwarded once.
            m.aw_valid  = s1.aw_valid & ~aw_done;
            s1.aw_ready = m.aw_ready & ~aw_done;
            m.w_valid   = s1.w_valid & ~w_done;
            s1.w_ready  = m.w_ready & ~w_done;
            // B is forwarded even if memory answers before both beats land.
            s1.b_valid  = m.b_valid;
            m.b_ready   = s1.b_ready;
         end
         default: begin
         end
      endcase
   end

   // Next-state: arbitrate in IDLE, return to IDLE on the response handshake.
   always_comb begin
      state_next = state;
      grant_next = grant;

      case (state)
         IDLE: begin
            if (wr_req) begin
               state_next = WR1;
            end else if (both_rd) begin
`ifdef ARB_ROUND_ROBIN_EN
               state_next = last_rd ? RD0 : RD1;
`else
               state_next = RD1;
`endif
            end else if (s1.ar_valid) begin
               state_next = RD1;
            end else if (s0.ar_valid) begin
               state_next = RD0;
            end
         end
         RD0, RD1: begin
            if (r_hs) begin
               state_next = IDLE;
            end
         end
         WR1: begin
            if (b_hs) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase

      case (state_next)
         RD0:     grant_next = GRANT_RD0;
         RD1:     grant_next = GRANT_RD1;
         WR1:     grant_next = GRANT_WR1;
         default: grant_next = GRANT_NONE;
      endcase
   end

   // State and grant registers; reset abandons any in-flight transaction.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         grant <= GRANT_NONE;
      end else begin
         state <= state_next;
         grant <= grant_next;
      end
   end

   // Beat-done flags: set on their handshake, cleared when the response
   // completes, and held clear whenever no transaction is granted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ar_done <= 1'b0;
         aw_done <= 1'b0;
         w_done  <= 1'b0;
      end else begin
         case (state)
            RD0, RD1: begin
               aw_done <= 1'b0;
               w_done  <= 1'b0;
               if (r_hs) begin
                  ar_done <= 1'b0;
               end else if (ar_hs) begin
                  ar_done <= 1'b1;
               end
            end
            WR1: begin
               ar_done <= 1'b0;
               if (b_hs) begin
                  aw_done <= 1'b0;
                  w_done  <= 1'b0;
               end else begin
                  if (aw_hs) begin
                     aw_done <= 1'b1;
                  end
                  if (w_hs) begin
                     w_done <= 1'b1;
                  end
               end
            end
            default: begin
               ar_done <= 1'b0;
               aw_done <= 1'b0;
               w_done  <= 1'b0;
            end
         endcase
      end
   end

`ifdef ARB_ROUND_ROBIN_EN
   // Remember which read source was granted last (0 IFU, 1 LSU); starting at
   // 1 lets the IFU win the first tie after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_rd <= 1'b1;
      end else if (state == IDLE) begin
         if (state_next == RD0) begin
            last_rd <= 1'b0;
         end else if (state_next == RD1) begin
            last_rd <= 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_axi_mem_arbiter.sv
// tb_axi_mem_arbiter
// Directed bench for axi_mem_arbiter. Inputs change 1 time unit after the
// rising edge and outputs are sampled a further time unit later, well away
// from the active edge. Build with ARB_ROUND_ROBIN_EN defined to exercise
// the alternating-tie sequence instead of the fixed-priority tie.
module tb_axi_mem_arbiter;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [1:0] grant;

   int checks   = 0;
   int failures = 0;

   axi_mem_arbiter_if s0_bus ();
   axi_mem_arbiter_if s1_bus ();
   axi_mem_arbiter_if m_bus ();

   axi_mem_arbiter dut (
      .clk   (clk),
      .rst_n (rst_n),
      .s0    (s0_bus),
      .s1    (s1_bus),
      .m     (m_bus),
      .grant (grant)
   );

   // Free-running 10-unit clock.
   always #5 clk = ~clk;

   // Compare one observed value against its hand-computed expectation.
   task automatic check_output(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Return every bench-driven signal to its quiet value.
   task automatic apply_stimulus_idle();
      s0_bus.aw_addr  = '0; s0_bus.aw_valid = 1'b0;
      s0_bus.w_data   = '0; s0_bus.w_strb   = '0; s0_bus.w_valid = 1'b0;
      s0_bus.b_ready  = 1'b0;
      s0_bus.ar_addr  = '0; s0_bus.ar_valid = 1'b0;
      s0_bus.r_ready  = 1'b0;
      s1_bus.aw_addr  = '0; s1_bus.aw_valid = 1'b0;
      s1_bus.w_data   = '0; s1_bus.w_strb   = '0; s1_bus.w_valid = 1'b0;
      s1_bus.b_ready  = 1'b0;
      s1_bus.ar_addr  = '0; s1_bus.ar_valid = 1'b0;
      s1_bus.r_ready  = 1'b0;
      m_bus.aw_ready  = 1'b0;
      m_bus.w_ready   = 1'b0;
      m_bus.b_valid   = 1'b0;
      m_bus.ar_ready  = 1'b0;
      m_bus.r_data    = '0;
      m_bus.r_valid   = 1'b0;
   endtask

   // Pulse reset for one clock and release it just after an edge.
   task automatic apply_stimulus_reset();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      #1;
   endtask

   initial begin
      apply_stimulus_idle();
      rst_n = 1'b0;

      // ---- Reset: requests present but everything must stay quiet ----
      s0_bus.ar_addr  = 64'h8000_0000;
      s0_bus.ar_valid = 1'b1;
      m_bus.ar_ready  = 1'b1;
      m_bus.r_valid   = 1'b1;
      repeat (2) tick();
      #1;
      check_output("rst_grant",       grant,           2'b00);
      check_output("rst_m_ar_valid",  m_bus.ar_valid,  1'b0);
      check_output("rst_s0_ar_ready", s0_bus.ar_ready, 1'b0);
      check_output("rst_s0_r_valid",  s0_bus.r_valid,  1'b0);

      rst_n = 1'b1;
      m_bus.r_valid = 1'b0;
      #1;
      check_output("idle0_grant",      grant,           2'b00);
      check_output("idle0_m_ar_valid", m_bus.ar_valid,  1'b0);
      check_output("idle0_s0_ar_rdy",  s0_bus.ar_ready, 1'b0);
      check_output("idle0_m_r_ready",  m_bus.r_ready,   1'b0);

      // ---- IFU read with a 3-cycle R stall ----
      tick();
      #1;
      check_output("ifu_grant",      grant,           2'b01);
      check_output("ifu_m_ar_valid", m_bus.ar_valid,  1'b1);
      check_output("ifu_m_ar_addr",  m_bus.ar_addr,   64'h8000_0000);
      check_output("ifu_s0_ar_rdy",  s0_bus.ar_ready, 1'b1);
      tick();
      s0_bus.ar_valid = 1'b0;
      m_bus.r_data    = 64'h1122_3344_5566_7788;
      m_bus.r_valid   = 1'b1;
      s0_bus.r_ready  = 1'b0;
      #1;
      check_output("ifu_ar_once", m_bus.ar_valid, 1'b0);
      for (int i = 0; i < 3; i++) begin
         check_output("stall_grant",   grant,          2'b01);
         check_output("stall_r_valid", s0_bus.r_valid, 1'b1);
         check_output("stall_r_data",  s0_bus.r_data,  64'h1122_3344_5566_7788);
         check_output("stall_m_r_rdy", m_bus.r_ready,  1'b0);
         tick();
         #1;
      end
      s0_bus.r_ready = 1'b1;
      #1;
      check_output("ifu_m_r_ready", m_bus.r_ready, 1'b1);
      tick();
      m_bus.r_valid  = 1'b0;
      s0_bus.r_ready = 1'b0;
      #1;
      check_output("ifu_done_grant", grant,          2'b00);
      check_output("ifu_done_rvld",  s0_bus.r_valid, 1'b0);

      // ---- LSU write: W accepted two cycles before AW ----
      s1_bus.w_data  = 64'h0000_0000_DEAD_BEEF;
      s1_bus.w_strb  = 8'h0F;
      s1_bus.w_valid = 1'b1;
      m_bus.w_ready  = 1'b1;
      m_bus.aw_ready = 1'b1;
      #1;
      check_output("wr_req_idle_grant", grant,         2'b00);
      check_output("wr_req_idle_wvld",  m_bus.w_valid, 1'b0);
      tick();
      #1;
      check_output("wr_grant",        grant,           2'b11);
      check_output("wr_m_w_valid",    m_bus.w_valid,   1'b1);
      check_output("wr_m_w_data",     m_bus.w_data,    64'h0000_0000_DEAD_BEEF);
      check_output("wr_m_w_strb",     m_bus.w_strb,    8'h0F);
      check_output("wr_s1_w_ready",   s1_bus.w_ready,  1'b1);
      check_output("wr_m_aw_valid",   m_bus.aw_valid,  1'b0);
      check_output("wr_s0_ar_ready",  s0_bus.ar_ready, 1'b0);
      tick();
      #1;
      check_output("wr_w_once",       m_bus.w_valid,   1'b0);
      check_output("wr_w_rdy_masked", s1_bus.w_ready,  1'b0);
      s1_bus.w_valid = 1'b0;
      tick();
      s1_bus.aw_addr  = 64'h8000_0100;
      s1_bus.aw_valid = 1'b1;
      #1;
      check_output("wr_m_aw_valid2",  m_bus.aw_valid,  1'b1);
      check_output("wr_m_aw_addr",    m_bus.aw_addr,   64'h8000_0100);
      check_output("wr_s1_aw_ready",  s1_bus.aw_ready, 1'b1);
      check_output("wr_grant_hold",   grant,           2'b11);
      tick();
      #1;
      check_output("wr_aw_once",      m_bus.aw_valid,  1'b0);
      check_output("wr_aw_rdy_mask",  s1_bus.aw_ready, 1'b0);
      s1_bus.aw_valid = 1'b0;
      m_bus.b_valid   = 1'b1;
      s1_bus.b_ready  = 1'b1;
      #1;
      check_output("wr_s1_b_valid",   s1_bus.b_valid,  1'b1);
      check_output("wr_m_b_ready",    m_bus.b_ready,   1'b1);
      check_output("wr_s0_b_valid",   s0_bus.b_valid,  1'b0);
      tick();
      m_bus.b_valid  = 1'b0;
      s1_bus.b_ready = 1'b0;
      #1;
      check_output("wr_done_grant",   grant,           2'b00);
      check_output("wr_done_bvld",    s1_bus.b_valid,  1'b0);

`ifdef ARB_ROUND_ROBIN_EN
      // ---- Repeated read ties alternate, IFU first after reset ----
      apply_stimulus_reset();
      for (int i = 0; i < 4; i++) begin
         s0_bus.ar_addr  = 64'h8000_0040;
         s0_bus.ar_valid = 1'b1;
         s1_bus.ar_addr  = 64'h8000_0200;
         s1_bus.ar_valid = 1'b1;
         tick();
         #1;
         check_output("rr_grant", grant, (i % 2 == 0) ? 2'b01 : 2'b10);
         check_output("rr_m_ar_addr", m_bus.ar_addr,
                      (i % 2 == 0) ? 64'h8000_0040 : 64'h8000_0200);
         tick();
         s0_bus.ar_valid = 1'b0;
         s1_bus.ar_valid = 1'b0;
         m_bus.r_data    = 64'h0000_0000_0000_00AA;
         m_bus.r_valid   = 1'b1;
         s0_bus.r_ready  = 1'b1;
         s1_bus.r_ready  = 1'b1;
         tick();
         m_bus.r_valid  = 1'b0;
         s0_bus.r_ready = 1'b0;
         s1_bus.r_ready = 1'b0;
         #1;
         check_output("rr_done_grant", grant, 2'b00);
      end
`else
      // ---- Read tie under fixed priority: LSU first, then IFU ----
      s0_bus.ar_addr  = 64'h8000_0040;
      s0_bus.ar_valid = 1'b1;
      s1_bus.ar_addr  = 64'h8000_0200;
      s1_bus.ar_valid = 1'b1;
      tick();
      #1;
      check_output("tie_grant_lsu",  grant,           2'b10);
      check_output("tie_m_ar_addr",  m_bus.ar_addr,   64'h8000_0200);
      check_output("tie_s0_ar_rdy",  s0_bus.ar_ready, 1'b0);
      check_output("tie_s1_ar_rdy",  s1_bus.ar_ready, 1'b1);
      tick();
      s1_bus.ar_valid = 1'b0;
      m_bus.r_data    = 64'hA5A5_0000_0000_0200;
      m_bus.r_valid   = 1'b1;
      s1_bus.r_ready  = 1'b1;
      #1;
      check_output("tie_s1_r_valid", s1_bus.r_valid,  1'b1);
      check_output("tie_s1_r_data",  s1_bus.r_data,   64'hA5A5_0000_0000_0200);
      check_output("tie_s0_r_valid", s0_bus.r_valid,  1'b0);
      check_output("tie_s0_ar_rdy2", s0_bus.ar_ready, 1'b0);
      tick();
      m_bus.r_valid  = 1'b0;
      s1_bus.r_ready = 1'b0;
      #1;
      check_output("tie_rearb_gap",  grant,           2'b00);
      tick();
      #1;
      check_output("tie_grant_ifu",  grant,           2'b01);
      check_output("tie_ifu_addr",   m_bus.ar_addr,   64'h8000_0040);
      tick();
      s0_bus.ar_valid = 1'b0;
      m_bus.r_data    = 64'h5A5A_0000_0000_0040;
      m_bus.r_valid   = 1'b1;
      s0_bus.r_ready  = 1'b1;
      #1;
      check_output("tie_s0_r_data",  s0_bus.r_data,   64'h5A5A_0000_0000_0040);
      tick();
      m_bus.r_valid  = 1'b0;
      s0_bus.r_ready = 1'b0;
      #1;
      check_output("tie_done_grant", grant,           2'b00);
`endif

      // ---- Reset while in WR1 after the AW handshake ----
      s1_bus.aw_addr  = 64'h8000_0300;
      s1_bus.aw_valid = 1'b1;
      m_bus.aw_ready  = 1'b1;
      tick();
      #1;
      check_output("mid_grant_wr", grant, 2'b11);
      tick();
      s1_bus.aw_valid = 1'b0;
      s1_bus.w_data   = 64'h0000_0000_0BAD_F00D;
      s1_bus.w_strb   = 8'hFF;
      s1_bus.w_valid  = 1'b1;
      m_bus.w_ready   = 1'b1;
      m_bus.b_valid   = 1'b1;
      s1_bus.b_ready  = 1'b1;
      #1;
      check_output("mid_aw_done",    m_bus.aw_valid, 1'b0);
      check_output("mid_w_live",     m_bus.w_valid,  1'b1);
      rst_n = 1'b0;
      #1;
      check_output("mid_rst_grant",  grant,           2'b00);
      check_output("mid_rst_m_wvld", m_bus.w_valid,   1'b0);
      check_output("mid_rst_s1_wrdy",s1_bus.w_ready,  1'b0);
      check_output("mid_rst_s1_bvld",s1_bus.b_valid,  1'b0);
      check_output("mid_rst_m_brdy", m_bus.b_ready,   1'b0);
      check_output("mid_rst_awrdy",  s1_bus.aw_ready, 1'b0);
      s1_bus.w_valid = 1'b0;
      s1_bus.b_ready = 1'b0;
      m_bus.b_valid  = 1'b0;
      tick();
      rst_n = 1'b1;
      #1;
      check_output("post_rst_grant", grant, 2'b00);

      // ---- A fresh IFU read completes normally after reset ----
      s0_bus.ar_addr  = 64'h8000_0080;
      s0_bus.ar_valid = 1'b1;
      tick();
      #1;
      check_output("post_grant",      grant,          2'b01);
      check_output("post_m_ar_valid", m_bus.ar_valid, 1'b1);
      check_output("post_m_ar_addr",  m_bus.ar_addr,  64'h8000_0080);
      tick();
      s0_bus.ar_valid = 1'b0;
      m_bus.r_data    = 64'h0123_4567_89AB_CDEF;
      m_bus.r_valid   = 1'b1;
      s0_bus.r_ready  = 1'b1;
      #1;
      check_output("post_r_valid",    s0_bus.r_valid, 1'b1);
      check_output("post_r_data",     s0_bus.r_data,  64'h0123_4567_89AB_CDEF);
      tick();
      m_bus.r_valid  = 1'b0;
      s0_bus.r_ready = 1'b0;
      #1;
      check_output("post_done_grant", grant, 2'b00);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
